// File: rtl/loa_error_monitor.sv
// loa_error_monitor: error statistics for a lower-part OR approximate adder.
// Forms the exact sum of each accepted operand pair and accumulates, over a
// window of WINDOW samples, the sample count, the erroneous-sample count, the
// saturating sum of error distances and the maximum error distance.
// Optional macro LOA_BIAS_ACC_EN adds a signed saturating bias accumulator
// (approx - exact) on output bias_sum.
module loa_error_monitor #(
    parameter int N      = 16,
    parameter int P      = 8,
    parameter int WINDOW = 1024,
    parameter int CNT_W  = 16,
    parameter int ACC_W  = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     x,
    input  logic [N-1:0]     y,
    input  logic [N:0]       approx_sum,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] sample_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic [ACC_W-1:0] ed_sum,
    output logic [N:0]       ed_max
`ifdef LOA_BIAS_ACC_EN
    ,
    output logic signed [ACC_W-1:0] bias_sum
`endif
);

    // Wide enough to hold either operand of the saturating add plus a carry.
    localparam int SUM_W = ((ACC_W > N + 1) ? ACC_W : N + 1) + 1;

    // P documents the adder split only; reject an impossible split early.
    if (P > N) begin : g_p_check
        $error("loa_error_monitor: P must not exceed N");
    end
    if (WINDOW < 1 || WINDOW > (2 ** CNT_W) - 1) begin : g_window_check
        $error("loa_error_monitor: WINDOW out of range for CNT_W");
    end

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] acc_cnt_q, acc_cnt_d;
    logic             drain_q, drain_d;
    logic             done_q, done_d;
    logic             s1_vld_q, s1_vld_d;
    logic [N:0]       exact_q, exact_d;
    logic [N:0]       approx_q, approx_d;
    logic [CNT_W-1:0] sample_cnt_q, sample_cnt_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic [ACC_W-1:0] ed_sum_q, ed_sum_d;
    logic [N:0]       ed_max_q, ed_max_d;
    logic [N:0]       ed;
    logic [SUM_W-1:0] sum_w;
    logic             accept;
    logic             clear;

    assign in_ready = (state_q == RUN);
    assign busy     = (state_q == RUN) || (state_q == DRAIN);
    assign accept   = in_valid & in_ready;
    assign clear    = start & ((state_q == IDLE) || (state_q == DONE));

    // Run control: count accepts, then drain the two-deep pipeline.
    always_comb begin
        state_d   = state_q;
        acc_cnt_d = acc_cnt_q;
        drain_d   = drain_q;
        done_d    = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d   = RUN;
                    acc_cnt_d = '0;
                end
            end
            RUN: begin
                if (accept) begin
                    acc_cnt_d = acc_cnt_q + CNT_W'(1);
                    if (acc_cnt_q == CNT_W'(WINDOW - 1)) begin
                        state_d = DRAIN;
                        drain_d = 1'b0;
                    end
                end
            end
            DRAIN: begin
                drain_d = 1'b1;
                if (drain_q) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    drain_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Stage 1: capture exact sum and approximate sum on accept only.
    always_comb begin
        s1_vld_d = accept;
        exact_d  = exact_q;
        approx_d = approx_q;
        if (accept) begin
            exact_d  = {1'b0, x} + {1'b0, y};
            approx_d = approx_sum;
        end
    end

    // Stage 2: error distance and statistics update; start clears.
    always_comb begin
        ed           = (exact_q >= approx_q) ? (exact_q - approx_q) : (approx_q - exact_q);
        sum_w        = SUM_W'(ed_sum_q) + SUM_W'(ed);
        sample_cnt_d = sample_cnt_q;
        err_cnt_d    = err_cnt_q;
        ed_sum_d     = ed_sum_q;
        ed_max_d     = ed_max_q;
        if (clear) begin
            sample_cnt_d = '0;
            err_cnt_d    = '0;
            ed_sum_d     = '0;
            ed_max_d     = '0;
        end else if (s1_vld_q) begin
            sample_cnt_d = sample_cnt_q + CNT_W'(1);
            if (ed != '0) err_cnt_d = err_cnt_q + CNT_W'(1);
            ed_sum_d = (sum_w > SUM_W'({ACC_W{1'b1}})) ? {ACC_W{1'b1}} : sum_w[ACC_W-1:0];
            if (ed > ed_max_q) ed_max_d = ed;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            acc_cnt_q    <= '0;
            drain_q      <= 1'b0;
            done_q       <= 1'b0;
            s1_vld_q     <= 1'b0;
            exact_q      <= '0;
            approx_q     <= '0;
            sample_cnt_q <= '0;
            err_cnt_q    <= '0;
            ed_sum_q     <= '0;
            ed_max_q     <= '0;
        end else begin
            state_q      <= state_d;
            acc_cnt_q    <= acc_cnt_d;
            drain_q      <= drain_d;
            done_q       <= done_d;
            s1_vld_q     <= s1_vld_d;
            exact_q      <= exact_d;
            approx_q     <= approx_d;
            sample_cnt_q <= sample_cnt_d;
            err_cnt_q    <= err_cnt_d;
            ed_sum_q     <= ed_sum_d;
            ed_max_q     <= ed_max_d;
        end
    end

    assign done       = done_q;
    assign sample_cnt = sample_cnt_q;
    assign err_cnt    = err_cnt_q;
    assign ed_sum     = ed_sum_q;
    assign ed_max     = ed_max_q;

`ifdef LOA_BIAS_ACC_EN
    localparam int BIAS_W = ((ACC_W > N + 2) ? ACC_W : N + 2) + 1;

    logic signed [ACC_W-1:0]  bias_q, bias_d;
    logic signed [N+1:0]      diff;
    logic signed [BIAS_W-1:0] bias_w;
    logic signed [BIAS_W-1:0] bmax;
    logic signed [BIAS_W-1:0] bmin;

    // Signed bias (approx - exact), clamped to the ACC_W signed range.
    always_comb begin
        diff   = $signed({1'b0, approx_q}) - $signed({1'b0, exact_q});
        bias_w = BIAS_W'(bias_q) + BIAS_W'(diff);
        bmax   = {{(BIAS_W - ACC_W + 1){1'b0}}, {(ACC_W - 1){1'b1}}};
        bmin   = ~bmax;
        bias_d = bias_q;
        if (clear) begin
            bias_d = '0;
        end else if (s1_vld_q) begin
            if (bias_w > bmax)      bias_d = bmax[ACC_W-1:0];
            else if (bias_w < bmin) bias_d = bmin[ACC_W-1:0];
            else                    bias_d = bias_w[ACC_W-1:0];
        end
    end

    // Bias accumulator register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) bias_q <= '0;
        else        bias_q <= bias_d;
    end

    assign bias_sum = bias_q;
`endif

endmodule

// File: tb/tb_loa_error_monitor.sv
// Scoreboard bench for loa_error_monitor: three instances (WINDOW=3/ACC_W=32,
// WINDOW=1/ACC_W=32, WINDOW=4/ACC_W=8) share the sample bus and are started
// one at a time. Expected run statistics come from a plain-arithmetic model.
module tb_loa_error_monitor;

    typedef struct { logic [15:0] x; logic [15:0] y; logic [16:0] a; } samp_t;
    typedef struct { int id; longint cnt; longint err; longint sum; longint mx; longint bias; } exp_t;

    logic        clk, rst_n, in_valid;
    logic [2:0]  start_v;
    logic [15:0] x, y;
    logic [16:0] approx;

    wire [2:0]  rdy, bsy, dn;
    wire [15:0] scnt [3];
    wire [15:0] ecnt [3];
    wire [31:0] esum [3];
    wire [16:0] emax [3];
    wire [7:0]  esum_c;
    assign esum[2] = {24'b0, esum_c};
`ifdef LOA_BIAS_ACC_EN
    wire signed [31:0] bias [3];
    wire signed [7:0]  bias_c;
    assign bias[2] = {{24{bias_c[7]}}, bias_c};
`endif

    int checks = 0;
    int errors = 0;
    exp_t exp_q[$];

    loa_error_monitor #(.N(16), .P(8), .WINDOW(3), .CNT_W(16), .ACC_W(32)) u_a (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]), .in_valid(in_valid), .in_ready(rdy[0]),
        .x(x), .y(y), .approx_sum(approx), .busy(bsy[0]), .done(dn[0]),
        .sample_cnt(scnt[0]), .err_cnt(ecnt[0]), .ed_sum(esum[0]), .ed_max(emax[0])
`ifdef LOA_BIAS_ACC_EN
        , .bias_sum(bias[0])
`endif
    );
    loa_error_monitor #(.N(16), .P(8), .WINDOW(1), .CNT_W(16), .ACC_W(32)) u_b (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]), .in_valid(in_valid), .in_ready(rdy[1]),
        .x(x), .y(y), .approx_sum(approx), .busy(bsy[1]), .done(dn[1]),
        .sample_cnt(scnt[1]), .err_cnt(ecnt[1]), .ed_sum(esum[1]), .ed_max(emax[1])
`ifdef LOA_BIAS_ACC_EN
        , .bias_sum(bias[1])
`endif
    );
    loa_error_monitor #(.N(16), .P(8), .WINDOW(4), .CNT_W(16), .ACC_W(8)) u_c (
        .clk(clk), .rst_n(rst_n), .start(start_v[2]), .in_valid(in_valid), .in_ready(rdy[2]),
        .x(x), .y(y), .approx_sum(approx), .busy(bsy[2]), .done(dn[2]),
        .sample_cnt(scnt[2]), .err_cnt(ecnt[2]), .ed_sum(esum_c), .ed_max(emax[2])
`ifdef LOA_BIAS_ACC_EN
        , .bias_sum(bias_c)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void chk(string nm, longint act, longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", nm, act, exp);
        end
    endfunction

    function automatic int win(int id);
        return (id == 0) ? 3 : ((id == 1) ? 1 : 4);
    endfunction

    function automatic int accw(int id);
        return (id == 2) ? 8 : 32;
    endfunction

    function automatic samp_t mk(logic [15:0] xx, logic [15:0] yy, logic [16:0] aa);
        samp_t s;
        s.x = xx; s.y = yy; s.a = aa;
        return s;
    endfunction

    // Random sample: exact, LOA-style (8-bit OR lower part) or arbitrary approx.
    function automatic samp_t rnd_samp();
        samp_t s;
        int mode;
        logic [8:0] hi;
        s.x  = 16'($urandom);
        s.y  = 16'($urandom);
        mode = $urandom_range(0, 3);
        hi   = 9'(s.x[15:8]) + 9'(s.y[15:8]) + 9'(s.x[7] & s.y[7]);
        if (mode == 0)      s.a = 17'(s.x) + 17'(s.y);
        else if (mode == 3) s.a = 17'($urandom);
        else                s.a = {hi, s.x[7:0] | s.y[7:0]};
        return s;
    endfunction

    // Reference: statistics of a whole window from the error-distance rules.
    function automatic exp_t model(int id, samp_t s[$]);
        exp_t e;
        longint amax = (longint'(1) << accw(id)) - 1;
        longint bmax = (longint'(1) << (accw(id) - 1)) - 1;
        longint bmin = -(longint'(1) << (accw(id) - 1));
        e.id = id; e.cnt = 0; e.err = 0; e.sum = 0; e.mx = 0; e.bias = 0;
        foreach (s[i]) begin
            longint d  = longint'(s[i].a) - (longint'(s[i].x) + longint'(s[i].y));
            longint ed = (d < 0) ? -d : d;
            e.cnt++;
            if (ed != 0) e.err++;
            e.sum  = (e.sum + ed > amax) ? amax : e.sum + ed;
            e.mx   = (ed > e.mx) ? ed : e.mx;
            e.bias = e.bias + d;
            if (e.bias > bmax) e.bias = bmax;
            if (e.bias < bmin) e.bias = bmin;
        end
        return e;
    endfunction

    task automatic chk_zero(input string tag, input int id);
        chk({tag, "_ready"}, rdy[id], 0);
        chk({tag, "_busy"}, bsy[id], 0);
        chk({tag, "_done"}, dn[id], 0);
        chk({tag, "_scnt"}, scnt[id], 0);
        chk({tag, "_ecnt"}, ecnt[id], 0);
        chk({tag, "_esum"}, esum[id], 0);
        chk({tag, "_emax"}, emax[id], 0);
`ifdef LOA_BIAS_ACC_EN
        chk({tag, "_bias"}, bias[id], 0);
`endif
    endtask

    // One measurement run. gap: 0 back-to-back, 1 alternating, 2 random.
    task automatic run(input int id, input samp_t s[$], input int gap,
                       input bit mid_start, input bit junk_start);
        int i = 0, t = 0, k;
        bit v, acc;
        exp_q.push_back(model(id, s));
        @(negedge clk);
        start_v[id] = 1'b1;
        in_valid = junk_start;
        x = 16'($urandom); y = 16'($urandom); approx = 17'($urandom);
        @(negedge clk);
        start_v[id] = 1'b0;
        in_valid = 1'b0;
        chk("start_busy", bsy[id], 1);
        chk("start_scnt", scnt[id], 0);
        chk("start_ecnt", ecnt[id], 0);
        chk("start_esum", esum[id], 0);
        chk("start_emax", emax[id], 0);
        while (i < s.size() && t < 1000) begin
            v = (gap == 0) ? 1'b1 : ((gap == 1) ? (t % 2 == 0) : 1'($urandom_range(0, 1)));
            in_valid = v;
            if (v) begin x = s[i].x; y = s[i].y; approx = s[i].a; end
            start_v[id] = mid_start && (i == 1);
            acc = v && rdy[id];
            @(negedge clk);
            t++;
            if (acc) i++;
        end
        start_v[id] = 1'b0;
        in_valid = 1'b0;
        if (t >= 1000) chk("accept_timeout", i, s.size());
        chk("ready_after_last", rdy[id], 0);
        k = 1;
        while (!dn[id] && k < 10) begin
            @(negedge clk);
            k++;
        end
        chk("done_latency", k, 3);
    endtask

    // Scoreboard monitor: every done pulse pops and checks one expected run.
    logic [2:0] dn_prev;
    always @(negedge clk) begin
        exp_t e;
        for (int i = 0; i < 3; i++) begin
            if (dn[i]) begin
                if (dn_prev[i]) chk("done_width", 2, 1);
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", i, -1);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_id", i, e.id);
                    chk("sb_scnt", scnt[i], e.cnt);
                    chk("sb_ecnt", ecnt[i], e.err);
                    chk("sb_esum", esum[i], e.sum);
                    chk("sb_emax", emax[i], e.mx);
`ifdef LOA_BIAS_ACC_EN
                    chk("sb_bias", bias[i], e.bias);
`endif
                end
            end
        end
        dn_prev <= dn;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        samp_t s[$];
        rst_n = 1'b0; start_v = '0; in_valid = 1'b0; x = '0; y = '0; approx = '0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) chk_zero("rst", i);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 3; i++) chk_zero("post_rst", i);

        // WINDOW=1, single sample with ed=1
        s = {};
        s.push_back(mk(16'h00FF, 16'h0001, 17'h000FF));
        run(1, s, 0, 0, 0);
        chk("w1_scnt", scnt[1], 1);
        chk("w1_ecnt", ecnt[1], 1);
        chk("w1_esum", esum[1], 1);
        chk("w1_emax", emax[1], 1);
`ifdef LOA_BIAS_ACC_EN
        chk("w1_bias", bias[1], -1);
`endif

        // WINDOW=3 directed, back-to-back then with bubbles
        s = {};
        s.push_back(mk(16'h0080, 16'h0080, 17'h00180));
        s.push_back(mk(16'h1200, 16'h0034, 17'h01234));
        s.push_back(mk(16'h00FF, 16'h0001, 17'h000FF));
        for (int g = 0; g < 2; g++) begin
            run(0, s, g, 0, 0);
            chk("w3_scnt", scnt[0], 3);
            chk("w3_ecnt", ecnt[0], 2);
            chk("w3_esum", esum[0], 129);
            chk("w3_emax", emax[0], 128);
`ifdef LOA_BIAS_ACC_EN
            chk("w3_bias", bias[0], 127);
`endif
            @(negedge clk);
            chk("hold_scnt", scnt[0], 3);
        end

        // ACC_W=8 saturation with ed=0x80 per sample
        s = {};
        repeat (4) s.push_back(mk(16'h0080, 16'h0080, 17'h00180));
        run(2, s, 0, 0, 0);
        chk("sat_esum", esum[2], 255);

        // Randomized runs on every instance, with ignored starts and
        // start coinciding with in_valid
        for (int r = 0; r < 30; r++) begin
            int id = r % 3;
            s = {};
            for (int j = 0; j < win(id); j++) s.push_back(rnd_samp());
            run(id, s, $urandom_range(0, 2), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        // Reset mid-run, between clock edges: run discarded, no done
        @(negedge clk);
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        in_valid = 1'b1; x = 16'h0001; y = 16'h0002; approx = 17'h00010;
        @(negedge clk);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk_zero("midrst", 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("midrst_idle_busy", bsy[0], 0);

        chk("sb_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/loa_error_monitor.md
Name: loa_error_monitor

Overview:
- Downstream characterisation stage for the lower-part OR approximate adder.
- Consumes the operand pair and the adder's approximate SUM, forms the exact sum internally, and accumulates error statistics over a fixed window of samples: sample count, erroneous-sample count, summed error distance and maximum error distance.
- Used on-chip and in simulation to grade a given N/P split without offline post-processing.

Parameters:
- N, 16, operand width; must match the adder instance.
- P, 8, approximate lower-part width; documentation only, not used in logic.
- WINDOW, 1024, samples per measurement run; legal range 1 to 2^CNT_W-1.
- CNT_W, 16, width of the sample and error counters.
- ACC_W, 32, width of the error-distance accumulator.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  single-cycle request to begin a run.
- in_valid  input  1  a sample is present on x, y and approx_sum.
- in_ready  output  1  the monitor accepts a sample this cycle.
- x  input  N  operand X.
- y  input  N  operand Y.
- approx_sum  input  N+1  SUM output of the approximate adder for x and y.
- busy  output  1  a run is in progress.
- done  output  1  single-cycle pulse when the run's statistics are final.
- sample_cnt  output  CNT_W  samples accepted in the current or last run.
- err_cnt  output  CNT_W  samples with nonzero error distance.
- ed_sum  output  ACC_W  sum of error distances, saturating.
- ed_max  output  N+1  largest error distance seen.

Behaviour:
- Reset (asynchronous on rst_n=0, independent of clk): state=IDLE; all outputs and pipeline registers 0, so in_ready=0, busy=0, done=0 and all stats=0. A reset mid-run discards the run with no done pulse.
- FSM states:
  - IDLE -> RUN on start=1. That same edge clears sample_cnt, err_cnt, ed_sum, ed_max and the internal accepted count.
  - RUN -> DRAIN on the edge that accepts sample number WINDOW.
  - DRAIN -> DONE after 2 cycles, once the pipeline is empty. done=1 for exactly that transition cycle.
  - DONE -> RUN on start=1, with the same clearing as from IDLE.
- start in RUN or DRAIN is ignored.
- busy=1 in RUN and DRAIN.
- in_ready=1 only in RUN, and is combinationally derived from state.
- Accept = in_valid & in_ready. x, y and approx_sum are sampled only on accept; inputs are don't-care otherwise.
- Pipeline:
  - Stage 1 registers exact = x+y (N+1 bits, unsigned) and approx_sum, plus a valid bit.
  - Stage 2 computes ed = |exact - approx_sum| (N+1 bits) and updates the statistics.
- Latency: an accepted sample is reflected in all outputs 2 clock edges after its accept edge.
- Statistics updates:
  - sample_cnt increments once per stage-2 valid sample.
  - err_cnt increments when ed != 0.
  - ed_sum += ed, saturating at all-ones; it never wraps.
  - ed_max = max(ed_max, ed).
- Statistics hold their values in DONE and IDLE until the next start.
- Back-to-back accepts every cycle are legal. Gaps in in_valid insert pipeline bubbles that do not update the statistics.
- Simultaneous start and in_valid in IDLE/DONE: the sample is not accepted (in_ready=0 that cycle); acceptance begins the next cycle.

Optional Feature:
- Macro: LOA_BIAS_ACC_EN.
- When defined:
  - Extra output bias_sum, signed, ACC_W bits, accumulating the signed difference approx_sum - exact in stage 2.
  - Saturates at the signed max/min; cleared on start and reset.
  - Same 2-cycle latency as the other statistics.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset: hold rst_n=0, then release -> in_ready=0, busy=0, all statistics 0. Drive rst_n=0 mid-run with no clock edge -> all outputs 0 immediately, and no done pulse follows.
- N=16, WINDOW=1, one sample x=0x00FF, y=0x0001, approx=0x00FF -> done pulse 3 cycles after accept; sample_cnt=1, err_cnt=1, ed_sum=1, ed_max=1; bias_sum=-1 if LOA_BIAS_ACC_EN.
- WINDOW=3, samples back-to-back:
  - (0x0080, 0x0080, approx 0x0180)
  - (0x1200, 0x0034, approx 0x1234)
  - (0x00FF, 0x0001, approx 0x00FF)
  - -> sample_cnt=3, err_cnt=2, ed_sum=129, ed_max=0x80; bias_sum=127.
- Same three samples as the previous scenario with in_valid toggling 1-0-1-0-1 -> identical final statistics; in_ready falls on the third accept edge; done fires exactly once.
- ACC_W=8 with repeated samples of ed=0x80 -> ed_sum holds 0xFF after the second sample and does not wrap.
- start pulsed during RUN -> ignored, counts continue. start in DONE -> statistics cleared to 0 on that edge, busy=1, and a new run proceeds.
